// File: rtl/alarm_bus_pkg.sv
// rtl/alarm_bus_pkg.sv - shared types, constants and helpers for the alarm bus poller
//
// Contents:
//   state_t      poller FSM encoding (IDLE, GRANT, SAMPLE, GAP)
//   PRESENT_BIT  position of the station "present" bit for the default 8-bit bus
//   CODE_NONE    alarm code meaning "no alarm"
//   room_w()     width of a room index for a given station count
//   present_bit() position of the present bit for an arbitrary bus width
package alarm_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam int DEFAULT_N   = 8;
    localparam int PRESENT_BIT = DEFAULT_N - 1;
    localparam int CODE_NONE   = 0;

    // A single-station bus still needs a one-bit index.
    function automatic int room_w(input int rooms);
        return (rooms > 1) ? $clog2(rooms) : 1;
    endfunction

    function automatic int present_bit(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/alarm_room_status.sv
// rtl/alarm_room_status.sv - per-room miss counter, fault flag and latched alarm
//
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   update         one-cycle strobe: this room's registered sample is being evaluated
//   present        present bit of the sample
//   has_code       sample carries a non-zero alarm code
//   ack            level-sensitive nurse acknowledge, clears alarm_active
//   alarm_active   latched alarm for this room
//   fault          station has missed MISS_LIMIT consecutive polls
module alarm_room_status #(
    parameter int MISS_LIMIT = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic update,
    input  logic present,
    input  logic has_code,
    input  logic ack,
    output logic alarm_active,
    output logic fault
);

    localparam logic [2:0] LIMIT = 3'(MISS_LIMIT);

    logic [2:0] miss_cnt;
    logic       new_alarm;

    assign new_alarm = update && present && has_code;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            miss_cnt     <= '0;
            fault        <= 1'b0;
            alarm_active <= 1'b0;
        end else begin
            if (update) begin
                if (!present) begin
                    if (miss_cnt != LIMIT) begin
                        miss_cnt <= miss_cnt + 3'd1;
                    end
                end else begin
                    miss_cnt <= '0;
                end
            end
            // Fault follows the counter one edge later, so it both sets and
            // clears on the cycle after the counter changes.
            fault        <= (miss_cnt == LIMIT);
            // A fresh alarm overrides a simultaneous acknowledge.
            alarm_active <= new_alarm | (alarm_active & ~ack);
        end
    end

endmodule

// File: rtl/alarm_bus_poller.sv
// rtl/alarm_bus_poller.sv - round-robin master for the shared room-alarm bus
//
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   poll_en        level-sensitive polling enable
//   bus_in         resolved shared bus (reads 0 when undriven)
//   ack            per-room nurse acknowledge
//   drv_en         one-hot tristate grant to the stations
//   busy           FSM is not in IDLE
//   room_id        room of the most recent alarm event
//   alarm_code     code of the most recent alarm event
//   alarm_valid    one-cycle pulse per alarm event
//   alarm_active   latched alarm per room
//   fault          non-responsive station flag per room
module alarm_bus_poller
    import alarm_bus_pkg::*;
#(
    parameter int N          = 8,
    parameter int ROOMS      = 4,
    parameter int SETTLE     = 2,
    parameter int MISS_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      poll_en,
    input  logic [N-1:0]              bus_in,
    input  logic [ROOMS-1:0]          ack,
    output logic [ROOMS-1:0]          drv_en,
    output logic                      busy,
    output logic [room_w(ROOMS)-1:0]  room_id,
    output logic [N-2:0]              alarm_code,
    output logic                      alarm_valid,
    output logic [ROOMS-1:0]          alarm_active,
    output logic [ROOMS-1:0]          fault
);

    localparam int              RW          = room_w(ROOMS);
    localparam int              PBIT        = present_bit(N);
    localparam logic [RW-1:0]   LAST_ROOM   = RW'(ROOMS - 1);
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    settle_cnt;
    logic [RW-1:0] ptr;
    logic [N-1:0]  sample;
    logic          update;
    logic          present;
    logic          has_code;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Once a slot starts it always runs through GAP, so
    // dropping poll_en only takes effect at the slot boundary.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (poll_en) state_nxt = ST_GRANT;
            ST_GRANT:  if (settle_cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = ST_GAP;
            ST_GAP:    state_nxt = poll_en ? ST_GRANT : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; GAP keeps every enable low for turnaround.
    always_comb begin
        drv_en = '0;
        if (state == ST_GRANT || state == ST_SAMPLE) begin
            drv_en[ptr] = 1'b1;
        end
        busy = (state != ST_IDLE);
    end

    // Slot counter, room pointer and sample register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            settle_cnt <= '0;
            ptr        <= '0;
            sample     <= '0;
        end else begin
            settle_cnt <= (state == ST_GRANT) ? settle_cnt + 4'd1 : 4'd0;
            if (state == ST_SAMPLE) begin
                sample <= bus_in;
            end
            if (state == ST_GAP) begin
                ptr <= (ptr == LAST_ROOM) ? '0 : ptr + RW'(1);
            end
        end
    end

    assign update   = (state == ST_GAP);
    assign present  = sample[PBIT];
    assign has_code = (sample[N-2:0] != (N-1)'(CODE_NONE));

    // Event outputs; alarm_code/room_id hold between events.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alarm_valid <= 1'b0;
            alarm_code  <= '0;
            room_id     <= '0;
        end else begin
            alarm_valid <= update && present && has_code;
            if (update && present && has_code) begin
                alarm_code <= sample[N-2:0];
                room_id    <= ptr;
            end
        end
    end

    for (genvar i = 0; i < ROOMS; i++) begin : g_room
        alarm_room_status #(
            .MISS_LIMIT (MISS_LIMIT)
        ) u_status (
            .clk          (clk),
            .reset_n      (reset_n),
            .update       (update && (ptr == RW'(i))),
            .present      (present),
            .has_code     (has_code),
            .ack          (ack[i]),
            .alarm_active (alarm_active[i]),
            .fault        (fault[i])
        );
    end

endmodule
